tdpsram_arbiter: RTL

//  Shares one true-dual-port SRAM (two ports, 1-cycle read latency, write-first, byte-lane WE)

---
 rtl/tdpsram_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tdpsram_arbiter.sv
// tdpsram_arbiter: shares one true-dual-port SRAM among NREQ requesters.
// Each cycle grants up to two requesters in round-robin order (port A, port B),
// never the same address on both ports, and returns the SRAM read data one
// cycle later on the requester's own response slice.
// Optional build macro TDPSRAM_CLEAR_EN: after reset the arbiter first zeroes
// the whole SRAM (two words per cycle) before accepting requests.
module tdpsram_arbiter #(
  parameter  int NREQ       = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int DATA_DEPTH = 1024,
  parameter  int BYTE_SIZE  = 8,
  localparam int AW         = $clog2(DATA_DEPTH),
  localparam int WE_W       = DATA_WIDTH / BYTE_SIZE,
  localparam int DW         = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*WE_W-1:0] req_we_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [NREQ*DW-1:0]   rsp_rdata_o,
  output logic                 init_done_o,
  output logic [AW-1:0]        addr0_o,
  output logic [AW-1:0]        addr1_o,
  output logic                 en0_o,
  output logic                 en1_o,
  output logic [WE_W-1:0]      we0_o,
  output logic [WE_W-1:0]      we1_o,
  output logic [DW-1:0]        wdata0_o,
  output logic [DW-1:0]        wdata1_o,
  input  logic [DW-1:0]        rdata0_i,
  input  logic [DW-1:0]        rdata1_i
);

  localparam int PW = $clog2(NREQ);

  logic [AW-1:0]   addr_a  [NREQ];
  logic [WE_W-1:0] we_a    [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];

  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] sel_valid_q;
  logic [NREQ-1:0] sel_port_q;
  logic [NREQ-1:0] portb_mask;
  logic            init_done_q;
  logic            accept;
  logic            g0_found, g1_found;
  logic [PW-1:0]   g0_idx, g1_idx;

  // Unpack the flat request buses into per-requester arrays.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_a[gi]  = req_addr_i[gi*AW +: AW];
      assign we_a[gi]    = req_we_i[gi*WE_W +: WE_W];
      assign wdata_a[gi] = req_wdata_i[gi*DW +: DW];
    end
  endgenerate

  // Requests are only considered in the running state and never while rst is high.
  assign accept      = init_done_q && !rst;
  assign init_done_o = init_done_q;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Round-robin scan from ptr: first valid gets port A, next valid with a different address gets port B.
  always_comb begin
    int idx;
    idx      = 0;
    g0_found = 1'b0;
    g0_idx   = '0;
    g1_found = 1'b0;
    g1_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (accept && req_valid_i[idx]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = PW'(idx);
        end else if (!g1_found && (addr_a[idx] != addr_a[g0_idx])) begin
          g1_found = 1'b1;
          g1_idx   = PW'(idx);
        end
      end
    end
  end

  // Per-requester grant and port-B selection masks plus the response slices.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign portb_mask[gi]  = g1_found && (g1_idx == PW'(gi));
      assign req_ready_o[gi] = (g0_found && (g0_idx == PW'(gi))) || portb_mask[gi];
      assign rsp_valid_o[gi] = sel_valid_q[gi] && !rst;
      assign rsp_rdata_o[gi*DW +: DW] = !sel_valid_q[gi] ? '0 :
                                        (sel_port_q[gi] ? rdata1_i : rdata0_i);
    end
  endgenerate

`ifdef TDPSRAM_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t        state_q;
  logic [AW:0]   clr_q;
  logic [AW:0]   clr_plus1;
  assign clr_plus1 = clr_q + (AW+1)'(1);

  // Clear FSM: sweep the SRAM two words per cycle, then enter RUN and open the arbiter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (clr_q + (AW+1)'(2) >= (AW+1)'(DATA_DEPTH)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            clr_q <= clr_q + (AW+1)'(2);
          end
        end
        default: init_done_q <= 1'b1;
      endcase
    end
  end
`else
  // Without the clear sweep the arbiter opens one cycle after reset release.
  always_ff @(posedge clk) begin
    if (rst) init_done_q <= 1'b0;
    else     init_done_q <= 1'b1;
  end
`endif

  // SRAM port drive: clear sweep when initialising, otherwise the two granted requesters.
  always_comb begin
    en0_o    = 1'b0;
    addr0_o  = '0;
    we0_o    = '0;
    wdata0_o = '0;
    en1_o    = 1'b0;
    addr1_o  = '0;
    we1_o    = '0;
    wdata1_o = '0;
`ifdef TDPSRAM_CLEAR_EN
    if (state_q == ST_INIT && !rst) begin
      en0_o   = 1'b1;
      addr0_o = clr_q[AW-1:0];
      we0_o   = '1;
      if (clr_plus1 < (AW+1)'(DATA_DEPTH)) begin
        en1_o   = 1'b1;
        addr1_o = clr_plus1[AW-1:0];
        we1_o   = '1;
      end
    end
`endif
    if (g0_found) begin
      en0_o    = 1'b1;
      addr0_o  = addr_a[g0_idx];
      we0_o    = we_a[g0_idx];
      wdata0_o = wdata_a[g0_idx];
    end
    if (g1_found) begin
      en1_o    = 1'b1;
      addr1_o  = addr_a[g1_idx];
      we1_o    = we_a[g1_idx];
      wdata1_o = wdata_a[g1_idx];
    end
  end

  // Advance the round-robin pointer past the last grant and remember who gets a response on which port.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      sel_valid_q <= '0;
      sel_port_q  <= '0;
    end else begin
      sel_valid_q <= req_ready_o;
      sel_port_q  <= portb_mask;
      if (g1_found)      ptr_q <= next_idx(g1_idx);
      else if (g0_found) ptr_q <= next_idx(g0_idx);
    end
  end

endmodule
